// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: drives datapath selects/enables per state and counts retired instructions.
// Outputs are Moore (one cycle per state); stall or reset masks every write enable while selects track the state.
module mips_multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             stall,
    output logic             iord,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_control,
    output logic [1:0]       pc_src,
    output logic             pc_en,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic             w_hold;
    logic             w_mem_write;
    logic             w_ir_write;
    logic             w_reg_write;
    logic             w_pc_en;
    logic             w_done;
    logic             w_illegal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_count <= '0;
        end else if (!stall) begin
            r_state <= w_next;
            if (w_done)
                r_count <= r_count + CNT_W'(1);
        end
    end

    always_comb begin
        w_next      = S_FETCH;
        iord        = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        pc_src      = 2'b00;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_pc_en     = 1'b0;
        w_done      = 1'b0;
        w_illegal   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_next      = S_DECODE;
                w_ir_write  = 1'b1;
                alu_src_b   = 2'b01;
                alu_control = 3'b010;
                w_pc_en     = 1'b1;
            end
            S_DECODE: begin
                alu_src_b   = 2'b11;
                alu_control = 3'b010;
                case (opcode)
                    OP_LW, OP_SW:   w_next = S_MEMADR;
                    OP_RTYPE:       w_next = S_EXECUTE;
                    OP_BEQ, OP_BNE: w_next = S_BRANCH;
                    OP_ADDI:        w_next = S_ADDIEX;
                    OP_J:           w_next = S_JUMP;
                    default:        w_illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                w_next      = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = 3'b010;
            end
            S_MEMRD: begin
                w_next = S_MEMWB;
                iord   = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg  = 1'b1;
                w_reg_write = 1'b1;
                w_done      = 1'b1;
            end
            S_MEMWR: begin
                iord        = 1'b1;
                w_mem_write = 1'b1;
                w_done      = 1'b1;
            end
            S_EXECUTE: begin
                w_next    = S_ALUWB;
                alu_src_a = 1'b1;
                case (funct)
                    6'b100010: alu_control = 3'b110;
                    6'b100100: alu_control = 3'b000;
                    6'b100101: alu_control = 3'b001;
                    6'b101010: alu_control = 3'b111;
                    default:   alu_control = 3'b010;
                endcase
            end
            S_ALUWB: begin
                reg_dst     = 1'b1;
                w_reg_write = 1'b1;
                w_done      = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = 3'b110;
                pc_src      = 2'b01;
                // opcode[0] distinguishes bne from beq
                w_pc_en     = zero ^ opcode[0];
                w_done      = 1'b1;
            end
            S_ADDIEX: begin
                w_next      = S_ADDIWB;
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = 3'b010;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
                w_done      = 1'b1;
            end
            S_JUMP: begin
                pc_src  = 2'b10;
                w_pc_en = 1'b1;
                w_done  = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    assign w_hold      = stall | reset;
    assign mem_write   = w_mem_write & ~w_hold;
    assign ir_write    = w_ir_write  & ~w_hold;
    assign reg_write   = w_reg_write & ~w_hold;
    assign pc_en       = w_pc_en     & ~w_hold;
    assign instr_done  = w_done      & ~w_hold;
    assign illegal     = w_illegal   & ~w_hold;
    assign state       = r_state;
    assign instr_count = r_count;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized scoreboard bench: instruction-level path model predicts per-cycle outputs, negedge monitor compares.
module tb_mips_multicycle_control;

    logic        clk = 1'b0;
    logic        reset, zero, stall;
    logic [5:0]  opcode, funct;
    logic        iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, pc_src;
    logic [2:0]  alu_control;
    logic        pc_en, instr_done, illegal;
    logic [3:0]  state;
    logic [31:0] instr_count;

    typedef struct packed {
        logic [3:0]  st;
        logic        iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic [1:0]  alu_src_b;
        logic [2:0]  alu_control;
        logic [1:0]  pc_src;
        logic        pc_en, instr_done, illegal;
        logic [31:0] cnt;
    } obs_t;

    obs_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned m_cnt   = 0;
    bit          rnd_stall = 0;
    int          zmode = -1;

    mips_multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .stall(stall),
        .iord(iord), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_control(alu_control), .pc_src(pc_src), .pc_en(pc_en),
        .state(state), .instr_done(instr_done), .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    function automatic obs_t snap();
        obs_t a;
        a = {state, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
             alu_src_b, alu_control, pc_src, pc_en, instr_done, illegal, instr_count};
        return a;
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b000010};
    endfunction

    // Expected outputs of one cycle, straight from the per-state output table
    function automatic obs_t model(input int st, input bit stl, input bit rst, input logic [5:0] op,
                                   input logic [5:0] fn, input bit z, input int unsigned cnt);
        obs_t o;
        o     = '0;
        o.st  = 4'(st);
        o.cnt = cnt;
        case (st)
            0:  begin o.ir_write = 1; o.alu_src_b = 2'b01; o.alu_control = 3'b010; o.pc_en = 1; end
            1:  begin o.alu_src_b = 2'b11; o.alu_control = 3'b010; o.illegal = !is_legal(op); end
            2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_control = 3'b010; end
            3:  o.iord = 1;
            4:  begin o.mem_to_reg = 1; o.reg_write = 1; o.instr_done = 1; end
            5:  begin o.iord = 1; o.mem_write = 1; o.instr_done = 1; end
            6:  begin
                    o.alu_src_a = 1;
                    case (fn)
                        6'b100010: o.alu_control = 3'b110;
                        6'b100100: o.alu_control = 3'b000;
                        6'b100101: o.alu_control = 3'b001;
                        6'b101010: o.alu_control = 3'b111;
                        default:   o.alu_control = 3'b010;
                    endcase
                end
            7:  begin o.reg_dst = 1; o.reg_write = 1; o.instr_done = 1; end
            8:  begin o.alu_src_a = 1; o.alu_control = 3'b110; o.pc_src = 2'b01;
                      o.pc_en = z ^ op[0]; o.instr_done = 1; end
            9:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_control = 3'b010; end
            10: begin o.reg_write = 1; o.instr_done = 1; end
            11: begin o.pc_src = 2'b10; o.pc_en = 1; o.instr_done = 1; end
            default: ;
        endcase
        if (stl || rst) begin
            o.ir_write = 0; o.mem_write = 0; o.reg_write = 0;
            o.pc_en = 0; o.instr_done = 0; o.illegal = 0;
        end
        return o;
    endfunction

    task automatic check(input string name, input obs_t e);
        obs_t a;
        a = snap();
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s @%0t: got state=%0d vec=%h, expected state=%0d vec=%h",
                     name, $time, a.st, a, e.st, e);
        end
    endtask

    always @(negedge clk)
        if (q.size() != 0) check("cycle", q.pop_front());

    // Entered and left at posedge+1: drive this cycle's inputs and post its expectation
    task automatic cycle(input int st, input bit stl);
        stall = stl;
        zero  = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
        q.push_back(model(st, stl, 1'b0, opcode, funct, zero, m_cnt));
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int hold_st, input int hold_n);
        int p[$];
        int held;
        bit stl;
        held   = 0;
        opcode = op;
        funct  = fn;
        case (op)
            6'b100011:           p = '{0, 1, 2, 3, 4};
            6'b101011:           p = '{0, 1, 2, 5};
            6'b000000:           p = '{0, 1, 6, 7};
            6'b000100, 6'b000101: p = '{0, 1, 8};
            6'b001000:           p = '{0, 1, 9, 10};
            6'b000010:           p = '{0, 1, 11};
            default:             p = '{0, 1};
        endcase
        foreach (p[i]) begin
            do begin
                if (p[i] == hold_st && held < hold_n) begin
                    stl = 1;
                    held++;
                end else begin
                    stl = rnd_stall && ($urandom_range(0, 7) == 0);
                end
                cycle(p[i], stl);
            end while (stl);
        end
        if (is_legal(op)) m_cnt++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

    initial begin
        logic [5:0] ops[8];
        logic [5:0] fns[6];
        logic [5:0] op;
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b000010, 6'b111111};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b011011};

        reset = 1; stall = 0; zero = 0; opcode = 0; funct = 0;
        #1;
        q.push_back(model(0, 1'b0, 1'b1, opcode, funct, zero, 0));
        @(posedge clk);
        @(posedge clk);
        #1 reset = 0;

        run_instr(6'b100011, 6'd0,      -1, 0);
        run_instr(6'b101011, 6'd0,      -1, 0);
        run_instr(6'b000000, 6'b100000, -1, 0);
        run_instr(6'b000000, 6'b101010, -1, 0);
        zmode = 1; run_instr(6'b000100, 6'd0, -1, 0);
        zmode = 0; run_instr(6'b000100, 6'd0, -1, 0);
        zmode = 0; run_instr(6'b000101, 6'd0, -1, 0);
        zmode = 1; run_instr(6'b000101, 6'd0, -1, 0);
        zmode = -1;
        run_instr(6'b111111, 6'd0,      -1, 0);
        run_instr(6'b000000, 6'b100100,  7, 3);
        run_instr(6'b001000, 6'd0,      -1, 0);
        run_instr(6'b000010, 6'd0,      -1, 0);

        // Abandon an lw in MEMRD with an asynchronous reset
        opcode = 6'b100011; funct = 6'd0;
        cycle(0, 0); cycle(1, 0); cycle(2, 0);
        stall = 0;
        q.push_back(model(3, 1'b0, 1'b0, opcode, funct, zero, m_cnt));
        @(negedge clk);
        #1 reset = 1;
        #1 check("async_reset", model(0, 1'b0, 1'b1, opcode, funct, zero, 0));
        m_cnt = 0;
        @(posedge clk);
        #1 q.push_back(model(0, 1'b0, 1'b1, opcode, funct, zero, 0));
        @(posedge clk);
        #1 reset = 0;

        run_instr(6'b000000, 6'b100101, -1, 0);
        rnd_stall = 1;
        for (int n = 0; n < 150; n++) begin
            op = ops[$urandom_range(0, 7)];
            if (!is_legal(op)) begin
                do op = 6'($urandom_range(0, 63)); while (is_legal(op));
            end
            run_instr(op, fns[$urandom_range(0, 5)], -1, 0);
        end
        stall = 0;

        @(negedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
